// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope generator.
// Note-on/note-off pulses from the note parser are latched until the next
// audio sample strobe; the envelope level takes one step per strobe.
// Level arithmetic runs one bit wider than the level so it can saturate at
// full scale and clamp at zero instead of wrapping.
module adsr_envelope #(
  parameter int ENV_W  = 16,
  parameter int RATE_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              sampleEn,
  input  logic              noteTrig,
  input  logic              noteOff,
  input  logic [RATE_W-1:0] attackRate,
  input  logic [RATE_W-1:0] decayRate,
  input  logic [ENV_W-1:0]  sustainLevel,
  input  logic [RATE_W-1:0] releaseRate,
  output logic [ENV_W-1:0]  envLevel,
  output logic [2:0]        envState,
  output logic              envActive
);

  // Extended width used for all comparisons against full scale / thresholds.
  localparam int EXT = ENV_W + 1;
  localparam logic [EXT-1:0] MAX_EXT = {1'b0, {ENV_W{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [ENV_W-1:0] level_reg, level_next;
  logic             trig_pend_reg, trig_pend_next;
  logic             off_pend_reg, off_pend_next;

  // Effective events: a live pulse or one held over from an earlier cycle.
  logic trig_e;
  logic off_e;

  // Step arithmetic, all evaluated every cycle; the FSM picks what it needs.
  logic [EXT-1:0]   level_ext;
  logic [EXT-1:0]   attack_sum;
  logic [EXT-1:0]   decay_thresh;
  logic [EXT-1:0]   release_ext;
  logic             attack_sat;
  logic             decay_done;
  logic             release_done;
  logic [ENV_W-1:0] decay_step;
  logic [ENV_W-1:0] release_step;

  assign trig_e = noteTrig | trig_pend_reg;
  assign off_e  = noteOff  | off_pend_reg;

  assign level_ext    = EXT'(level_reg);
  assign attack_sum   = level_ext + EXT'(attackRate);
  assign decay_thresh = EXT'(sustainLevel) + EXT'(decayRate);
  assign release_ext  = EXT'(releaseRate);

  assign attack_sat   = (attack_sum >= MAX_EXT);
  assign decay_done   = (level_ext <= decay_thresh);
  assign release_done = (level_ext <= release_ext);

  // The subtractions below are only selected when the level is strictly
  // above the subtrahend, so they can never underflow when used.
  assign decay_step   = level_reg - ENV_W'(decayRate);
  assign release_step = level_reg - ENV_W'(releaseRate);

  // Pending-event latches: latest pulse wins, trig beats a coincident off,
  // and every sample strobe consumes whatever is pending.
  always_comb begin
    trig_pend_next = trig_pend_reg;
    off_pend_next  = off_pend_reg;
    if (sampleEn) begin
      trig_pend_next = 1'b0;
      off_pend_next  = 1'b0;
    end else if (noteTrig) begin
      trig_pend_next = 1'b1;
      off_pend_next  = 1'b0;
    end else if (noteOff) begin
      trig_pend_next = 1'b0;
      off_pend_next  = 1'b1;
    end
  end

  // Next state and level: events first, otherwise one step of the current phase.
  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    if (sampleEn) begin
      if (trig_e) begin
        // Retrigger keeps the current level so the attack starts smoothly.
        state_next = ST_ATTACK;
      end else if (off_e && (state_reg != ST_IDLE)) begin
        state_next = ST_RELEASE;
      end else begin
        unique case (state_reg)
          ST_IDLE: begin
            level_next = '0;
          end
          ST_ATTACK: begin
            if (attack_sat) begin
              level_next = MAX_EXT[ENV_W-1:0];
              state_next = ST_DECAY;
            end else begin
              level_next = attack_sum[ENV_W-1:0];
            end
          end
          ST_DECAY: begin
            if (decay_done) begin
              level_next = sustainLevel;
              state_next = ST_SUSTAIN;
            end else begin
              level_next = decay_step;
            end
          end
          ST_SUSTAIN: begin
            // Sustain level is live, so changes to it are followed immediately.
            level_next = sustainLevel;
          end
          ST_RELEASE: begin
            if (release_done) begin
              level_next = '0;
              state_next = ST_IDLE;
            end else begin
              level_next = release_step;
            end
          end
          default: begin
            // Unused encodings fall back to a silent idle voice.
            level_next = '0;
            state_next = ST_IDLE;
          end
        endcase
      end
    end
  end

  // State, level and pending-flag registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg     <= ST_IDLE;
      level_reg     <= '0;
      trig_pend_reg <= 1'b0;
      off_pend_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      trig_pend_reg <= trig_pend_next;
      off_pend_reg  <= off_pend_next;
    end
  end

  assign envLevel  = level_reg;
  assign envState  = state_reg;
  assign envActive = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed scenarios plus randomized stimulus checked
// against a behavioural envelope model kept in this bench.
module tb_adsr_envelope;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic        note_trig;
  logic        note_off;
  logic [15:0] attack_rate;
  logic [15:0] decay_rate;
  logic [15:0] sustain_level;
  logic [15:0] release_rate;
  logic [15:0] env_level;
  logic [2:0]  env_state;
  logic        env_active;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Behavioural model: level as a plain integer, phase as a number 0..4.
  int m_level = 0;
  int m_state = 0;
  bit m_trig_pend = 1'b0;
  bit m_off_pend  = 1'b0;

  adsr_envelope #(.ENV_W(16), .RATE_W(16)) dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .sampleEn     (sample_en),
    .noteTrig     (note_trig),
    .noteOff      (note_off),
    .attackRate   (attack_rate),
    .decayRate    (decay_rate),
    .sustainLevel (sustain_level),
    .releaseRate  (release_rate),
    .envLevel     (env_level),
    .envState     (env_state),
    .envActive    (env_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_update();
    bit te;
    bit oe;
    int s;
    if (!rst_n) begin
      m_level = 0;
      m_state = 0;
      m_trig_pend = 1'b0;
      m_off_pend  = 1'b0;
      return;
    end
    te = note_trig || m_trig_pend;
    oe = note_off  || m_off_pend;
    if (sample_en) begin
      if (te) m_state = 1;
      else if (oe && m_state != 0) m_state = 4;
      else begin
        case (m_state)
          0: m_level = 0;
          1: begin
            s = m_level + int'(attack_rate);
            if (s >= 65535) begin m_level = 65535; m_state = 2; end
            else m_level = s;
          end
          2: begin
            if (m_level <= int'(sustain_level) + int'(decay_rate)) begin
              m_level = int'(sustain_level); m_state = 3;
            end else m_level = m_level - int'(decay_rate);
          end
          3: m_level = int'(sustain_level);
          default: begin
            if (m_level <= int'(release_rate)) begin m_level = 0; m_state = 0; end
            else m_level = m_level - int'(release_rate);
          end
        endcase
      end
      m_trig_pend = 1'b0;
      m_off_pend  = 1'b0;
    end else if (note_trig) begin
      m_trig_pend = 1'b1; m_off_pend = 1'b0;
    end else if (note_off) begin
      m_trig_pend = 1'b0; m_off_pend = 1'b1;
    end
  endfunction

  // One clock: drive inputs at the falling edge, update the model at the
  // rising edge, return 1 ns later so outputs can be sampled.
  task automatic step(input bit trig, input bit off, input bit sen, input bit rst = 1'b1);
    @(negedge clk);
    note_trig = trig;
    note_off  = off;
    sample_en = sen;
    rst_n     = rst;
    @(posedge clk);
    model_update();
    #1;
    if (verbose)
      $display("txn rst_n=%0b trig=%0b off=%0b sen=%0b -> active=%0b state=%0d level=%0d",
               rst, trig, off, sen, env_active, env_state, env_level);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_ignores_pulse: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
  endtask

  task automatic test_attack();
    int exp_l[4] = '{16384, 32768, 49152, 65535};
    int exp_s[4] = '{1, 1, 1, 2};
    int prev;
    attack_rate = 16'd16384; decay_rate = 16'd10000;
    sustain_level = 16'd40000; release_rate = 16'd15000;
    step(1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b1, 3'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL attack_start: got act=%0b st=%0d lvl=%0d, want 1/1/0", env_active, env_state, env_level);
    end
    for (int i = 0; i < 4; i++) begin
      prev = (i == 0) ? 0 : exp_l[i-1];
      repeat (3) step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({env_state, env_level} !== {3'd1, 16'(prev)}) begin
        n_fail++;
        $display("FAIL attack_hold_%0d: got st=%0d lvl=%0d, want st=1 lvl=%0d", i, env_state, env_level, prev);
      end
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({env_state, env_level} !== {3'(exp_s[i]), 16'(exp_l[i])}) begin
        n_fail++;
        $display("FAIL attack_step_%0d: got st=%0d lvl=%0d, want st=%0d lvl=%0d",
                 i, env_state, env_level, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_decay_sustain();
    int exp_l[3] = '{55535, 45535, 40000};
    int exp_s[3] = '{2, 2, 3};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({env_state, env_level} !== {3'(exp_s[i]), 16'(exp_l[i])}) begin
        n_fail++;
        $display("FAIL decay_step_%0d: got st=%0d lvl=%0d, want st=%0d lvl=%0d",
                 i, env_state, env_level, exp_s[i], exp_l[i]);
      end
    end
    sustain_level = 16'd30000;
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd3, 16'd30000}) begin
      n_fail++;
      $display("FAIL sustain_live: got st=%0d lvl=%0d, want st=3 lvl=30000", env_state, env_level);
    end
    sustain_level = 16'd40000;
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd3, 16'd40000}) begin
      n_fail++;
      $display("FAIL sustain_restore: got st=%0d lvl=%0d, want st=3 lvl=40000", env_state, env_level);
    end
  endtask

  task automatic test_release();
    int exp_l[3] = '{25000, 10000, 0};
    int exp_s[3] = '{4, 4, 0};
    step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({env_state, env_level} !== {3'd3, 16'd40000}) begin
      n_fail++;
      $display("FAIL release_wait_strobe: got st=%0d lvl=%0d, want st=3 lvl=40000", env_state, env_level);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b1, 3'd4, 16'd40000}) begin
      n_fail++;
      $display("FAIL release_enter: got act=%0b st=%0d lvl=%0d, want 1/4/40000", env_active, env_state, env_level);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({env_active, env_state, env_level} !== {(exp_s[i] != 0), 3'(exp_s[i]), 16'(exp_l[i])}) begin
        n_fail++;
        $display("FAIL release_step_%0d: got act=%0b st=%0d lvl=%0d, want st=%0d lvl=%0d",
                 i, env_active, env_state, env_level, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    int exp_l[3] = '{41384, 57768, 65535};
    int exp_s[3] = '{1, 1, 2};
    attack_rate = 16'd40000;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd3, 16'd40000}) begin
      n_fail++;
      $display("FAIL retrig_setup: got st=%0d lvl=%0d, want st=3 lvl=40000", env_state, env_level);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd4, 16'd25000}) begin
      n_fail++;
      $display("FAIL retrig_release: got st=%0d lvl=%0d, want st=4 lvl=25000", env_state, env_level);
    end
    attack_rate = 16'd16384;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd1, 16'd25000}) begin
      n_fail++;
      $display("FAIL retrig_hold: got st=%0d lvl=%0d, want st=1 lvl=25000", env_state, env_level);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({env_state, env_level} !== {3'(exp_s[i]), 16'(exp_l[i])}) begin
        n_fail++;
        $display("FAIL retrig_step_%0d: got st=%0d lvl=%0d, want st=%0d lvl=%0d",
                 i, env_state, env_level, exp_s[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_event_order();
    // Same-cycle trig and off: trig wins.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd1, 16'd65535}) begin
      n_fail++;
      $display("FAIL order_same_cycle: got st=%0d lvl=%0d, want st=1 lvl=65535", env_state, env_level);
    end
    repeat (4) step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd3, 16'd40000}) begin
      n_fail++;
      $display("FAIL order_to_sustain: got st=%0d lvl=%0d, want st=3 lvl=40000", env_state, env_level);
    end
    // Trig then off: off is the latest event.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd4, 16'd40000}) begin
      n_fail++;
      $display("FAIL order_trig_then_off: got st=%0d lvl=%0d, want st=4 lvl=40000", env_state, env_level);
    end
    // Off then trig: trig is the latest event.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_state, env_level} !== {3'd1, 16'd40000}) begin
      n_fail++;
      $display("FAIL order_off_then_trig: got st=%0d lvl=%0d, want st=1 lvl=40000", env_state, env_level);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL order_release_idle: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
    // Off in IDLE is discarded, whether latched or coincident.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL order_off_in_idle: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL order_off_idle_sen: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
  endtask

  task automatic test_reset_mid();
    attack_rate = 16'd40000;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b1, 3'd2, 16'd65535}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got act=%0b st=%0d lvl=%0d, want 1/2/65535", env_active, env_state, env_level);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL rstmid_clear: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({env_active, env_state, env_level} !== {1'b0, 3'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL rstmid_pend_dropped: got act=%0b st=%0d lvl=%0d, want 0/0/0", env_active, env_state, env_level);
    end
  endtask

  task automatic test_random();
    bit t, o, s, r;
    verbose = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) attack_rate   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40000));
      if ($urandom_range(0, 99) == 0) decay_rate    = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
      if ($urandom_range(0, 99) == 0) release_rate  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
      if ($urandom_range(0, 49) == 0) sustain_level = 16'($urandom_range(0, 65535));
      t = ($urandom_range(0, 24) == 0);
      o = ($urandom_range(0, 14) == 0);
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 599) != 0);
      step(t, o, s, r);
      if (t || o || !r)
        $display("rnd %0d rst_n=%0b trig=%0b off=%0b sen=%0b -> state=%0d level=%0d",
                 i, r, t, o, s, env_state, env_level);
      n_checks++;
      if ({env_active, env_state, env_level} !== {(m_state != 0), 3'(m_state), 16'(m_level)}) begin
        n_fail++;
        $display("FAIL random_%0d: got act=%0b st=%0d lvl=%0d, want act=%0b st=%0d lvl=%0d",
                 i, env_active, env_state, env_level, (m_state != 0), m_state, m_level);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; note_trig = 1'b0; note_off = 1'b0;
    attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_event_order();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR amplitude envelope generator, directly downstream of the keyboard note parser. It consumes the parser's one-cycle `noteTrig` / `noteOff` pulses and produces an unsigned envelope level. The level advances once per audio sample strobe and multiplies the oscillator output in the voice mixer.

## Interface
Parameters:
- `ENV_W`, 16: envelope level width; full scale `MAX = 2^ENV_W - 1`.
- `RATE_W`, 16: width of the attack, decay and release rate inputs.

Ports:
- `Clk`  in  1  system clock; all logic on its rising edge.
- `Reset_n`  in  1  reset, synchronous, active-low.
- `sampleEn`  in  1  one-cycle strobe at the audio sample rate; the envelope advances only on cycles where it is high.
- `noteTrig`  in  1  one-cycle note-on pulse from the note parser.
- `noteOff`  in  1  one-cycle note-off pulse from the note parser.
- `attackRate`  in  RATE_W  amount added to the level per sample in ATTACK.
- `decayRate`  in  RATE_W  amount subtracted from the level per sample in DECAY.
- `sustainLevel`  in  ENV_W  level held in SUSTAIN; sampled live.
- `releaseRate`  in  RATE_W  amount subtracted from the level per sample in RELEASE.
- `envLevel`  out  ENV_W  registered envelope level.
- `envState`  out  3  registered state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `envActive`  out  1  high when `envState != IDLE`; combinational from the state register.

## Operation
- **Event latching.** Pulses can arrive on any cycle, so they are latched until the next sample strobe.
  - Two pending flags, `trigPend` and `offPend`, are set by pulses that arrive on a cycle with `sampleEn` low.
  - Effective events on a cycle are `trigE = noteTrig | trigPend` and `offE = noteOff | offPend`.
  - Latest event wins: `noteTrig` clears `offPend`, and `noteOff` clears `trigPend`.
  - If both pulses arrive in the same cycle, trig wins.
  - Both pending flags clear on every `sampleEn` cycle.
- **Priority on a `sampleEn` cycle:**
  1. `trigE`: next state is ATTACK and the level is held. Retrigger starts from the current level, with no reset to 0.
  2. Else `offE` and state is not IDLE: next state is RELEASE and the level is held. `offE` in IDLE is discarded.
  3. Else advance by state.
- **Advance by state.** All arithmetic is done at ENV_W+1 bits; the level never wraps.
  - IDLE: level = 0.
  - ATTACK: `sum = level + attackRate`. If `sum >= MAX`, level = MAX and go to DECAY; otherwise level = sum.
  - DECAY: if `level <= sustainLevel + decayRate`, level = `sustainLevel` and go to SUSTAIN; otherwise level = `level - decayRate`.
  - SUSTAIN: level = `sustainLevel`. The state stays SUSTAIN until `offE` or `trigE`.
  - RELEASE: if `level <= releaseRate`, level = 0 and go to IDLE; otherwise level = `level - releaseRate`.
- **Zero rates.** A rate of 0 holds the level in that state indefinitely. This is legal, not an error.
- **Cycles with `sampleEn` low.** Level and state hold; only the pending flags update.
- **Reset.** When `Reset_n` is low at a rising edge:
  - `envLevel` = 0, `envState` = IDLE, `envActive` = 0.
  - `trigPend` and `offPend` are cleared.
  - This takes effect mid-envelope, and any pulse in that same cycle is ignored.

## Timing
- Outputs are registered. A `sampleEn` cycle at edge t updates `envLevel` and `envState` at edge t+1.
- Event-to-state latency:
  - A pulse coincident with `sampleEn` changes state on the next edge.
  - Otherwise the state changes on the edge after the next `sampleEn`.
- Exactly one level step is taken per `sampleEn`; back-to-back `sampleEn` cycles are legal.
- No handshake: the upstream parser is never stalled, and a pulse is never lost unless it is superseded (latest event wins) or coincides with reset.

## Test plan
1. **Attack.** `attackRate`=16384; `noteTrig` with `sampleEn`; then `sampleEn` every 4 clocks -> state ATTACK at level 0, then levels 16384, 32768, 49152, 65535 (saturated from 65536), with state DECAY on the last step.
2. **Decay to sustain.** `decayRate`=10000, `sustainLevel`=40000, starting from 65535 -> levels 55535, 45535, then 40000 with state SUSTAIN. Changing `sustainLevel` to 30000 -> level 30000 on the next `sampleEn`.
3. **Release.** `noteOff` 2 clocks before `sampleEn`, with `releaseRate`=15000 at level 40000 -> RELEASE at 40000, then 25000, 10000, then 0 with IDLE; `envActive` falls with IDLE.
4. **Retrigger.** `noteTrig` during RELEASE at level 25000 with `attackRate`=16384 -> ATTACK holding 25000, then 41384, 57768, 65535.
5. **Event ordering.**
   - `noteTrig` and `noteOff` in the same cycle -> ATTACK.
   - `noteTrig` then `noteOff` before `sampleEn`, in SUSTAIN -> RELEASE.
   - `noteOff` then `noteTrig` -> ATTACK.
   - `noteOff` in IDLE -> stays IDLE at level 0.
6. **Reset mid-operation.** `Reset_n` low for 1 clock during DECAY with `trigPend` set -> next edge gives `envLevel`=0, `envState`=0, `envActive`=0. The following `sampleEn` leaves the state IDLE, because the pending trig was cleared.
